// File: rtl/search_pkg.sv
// Shared types for text_search_engine: query-edit opcodes, scan FSM states, case folding.
// SEARCH_CASE_FOLD_EN (in the top) decides whether fold_case is ever applied.
package search_pkg;

  typedef enum logic [1:0] {
    OP_APPEND    = 2'b00,
    OP_BACKSPACE = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_NONE      = 2'b11
  } q_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  // Maps 'A'..'Z' onto 'a'..'z'; every other code passes through untouched.
  function automatic int unsigned fold_case(input int unsigned c);
    return (c >= 32'd65 && c <= 32'd90) ? c + 32'd32 : c;
  endfunction

endpackage

// File: rtl/text_search_engine_if.sv
// Signal bundle of text_search_engine: query edit, scan control, text memory and highlight port.
// master = environment side, slave = engine side.
interface text_search_engine_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int QMAX   = 16,
  parameter int CHAR_W = 7
);
  localparam int QLW = $clog2(QMAX + 1);
  localparam int AW  = $clog2(COLS * ROWS);
  localparam int XW  = $clog2(COLS);
  localparam int YW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS * ROWS + 1);

  logic              q_valid;
  logic              q_ready;
  logic [1:0]        q_op;
  logic [CHAR_W-1:0] q_char;
  logic [QLW-1:0]    q_len;
  logic              fold;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [CHAR_W-1:0] mem_data;
  logic [XW-1:0]     hl_x;
  logic [YW-1:0]     hl_y;
  logic              hl_o;
  logic [CW-1:0]     match_count;

  modport master (
    output q_valid, q_op, q_char, fold, start, mem_data, hl_x, hl_y,
    input  q_ready, q_len, busy, done, mem_rd, mem_addr, hl_o, match_count
  );

  modport slave (
    input  q_valid, q_op, q_char, fold, start, mem_data, hl_x, hl_y,
    output q_ready, q_len, busy, done, mem_rd, mem_addr, hl_o, match_count
  );
endinterface

// File: rtl/search_window_cmp.sv
// Rolling window of the most recent characters of the current row, compared against the query.
// o_match fires for the incoming character when the row so far ends with query[0..len-1].
module search_window_cmp #(
  parameter  int QMAX   = 16,
  parameter  int CHAR_W = 7,
  localparam int QLW    = $clog2(QMAX + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic              i_row_start,
  input  logic [CHAR_W-1:0] i_char,
  input  logic [CHAR_W-1:0] i_query [QMAX],
  input  logic [QLW-1:0]    i_len,
  output logic              o_match
);

  logic [CHAR_W-1:0] r_hist [QMAX-1];
  logic [QLW-1:0]    r_cnt;
  logic [CHAR_W-1:0] w_win [QMAX];
  logic [QLW-1:0]    w_seen;
  logic              w_eq;

  // w_win[0] is the incoming character, w_win[j] the one j columns before it.
  always_comb begin
    w_win[0] = i_char;
    for (int j = 1; j < QMAX; j++) w_win[j] = r_hist[j-1];
  end

  // Characters of the row that precede the incoming one; history from earlier rows is never trusted.
  assign w_seen = i_row_start ? '0 : r_cnt;

  always_comb begin
    // NOTE: default first so every path assigns w_eq and no latch is inferred.
    w_eq = 1'b1;
    for (int j = 0; j < QMAX; j++) begin
      for (int k = 0; k < QMAX; k++) begin
        if ((j + k + 1 == int'(i_len)) && (w_win[j] != i_query[k])) w_eq = 1'b0;
      end
    end
  end

  assign o_match = i_valid && (i_len != '0) && (w_seen >= i_len - QLW'(1)) && w_eq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the history is a handful of flops, so it is reset like any other register.
      for (int j = 0; j < QMAX - 1; j++) r_hist[j] <= '0;
      r_cnt <= '0;
    end else if (i_valid) begin
      // NOTE: non-blocking assignments make the shift read every stage's old value.
      r_hist[0] <= i_char;
      for (int j = 1; j < QMAX - 1; j++) r_hist[j] <= r_hist[j-1];
      r_cnt <= i_row_start ? QLW'(1) :
               (r_cnt == QLW'(QMAX)) ? r_cnt : r_cnt + QLW'(1);
    end
  end

endmodule

// File: rtl/text_search_engine.sv
// Scans a COLS x ROWS text buffer for an editable query, counts matches and keeps a highlight bitmap.
// Optional SEARCH_CASE_FOLD_EN: when defined, fold=1 at start makes the scan case-insensitive.
module text_search_engine
  import search_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int QMAX   = 16,
  parameter int CHAR_W = 7
) (
  input  logic                 clk,
  input  logic                 resetn,
  text_search_engine_if.slave  bus
);

  localparam int N   = COLS * ROWS;
  localparam int QLW = $clog2(QMAX + 1);
  localparam int AW  = $clog2(N);
  localparam int XW  = $clog2(COLS);
  localparam int YW  = $clog2(ROWS);
  localparam int CW  = $clog2(N + 1);

  state_e            r_state, w_next;
  logic [QLW-1:0]    r_qlen;
  logic [CHAR_W-1:0] r_query [QMAX];
  logic [AW-1:0]     r_addr;
  logic [XW-1:0]     r_x, r_dx;
  logic [YW-1:0]     r_y, r_dy;
  logic              r_rd_d;
  logic [COLS-1:0]   r_bitmap [ROWS];
  logic [CW-1:0]     r_count;
  logic              r_hl;
  logic              w_busy, w_start_acc, w_edit, w_last, w_match;
  logic [COLS-1:0]   w_mask;
  logic [CHAR_W-1:0] w_char;
  logic [CHAR_W-1:0] w_qcmp [QMAX];

  assign w_busy      = (r_state == SCAN) || (r_state == DRAIN);
  assign w_start_acc = bus.start && !w_busy;
  assign w_edit      = bus.q_valid && !w_busy;
  assign w_last      = (r_addr == AW'(N - 1));

  assign bus.q_ready     = !w_busy;
  assign bus.q_len       = r_qlen;
  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == DONE);
  assign bus.mem_rd      = (r_state == SCAN);
  assign bus.mem_addr    = r_addr;
  assign bus.hl_o        = r_hl;
  assign bus.match_count = r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // An empty query skips straight to DONE, so done pulses without busy ever rising.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_start_acc ? ((r_qlen == '0) ? DONE : SCAN) : IDLE;
      SCAN:       if (w_last) w_next = DRAIN;
      DRAIN:      w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_qlen <= '0;
      for (int i = 0; i < QMAX; i++) r_query[i] <= '0;
    end else if (w_edit) begin
      case (q_op_e'(bus.q_op))
        OP_APPEND: if (r_qlen != QLW'(QMAX)) begin
          for (int i = 0; i < QMAX; i++) if (QLW'(i) == r_qlen) r_query[i] <= bus.q_char;
          r_qlen <= r_qlen + QLW'(1);
        end
        OP_BACKSPACE: if (r_qlen != '0) r_qlen <= r_qlen - QLW'(1);
        OP_CLEAR:     r_qlen <= '0;
        default:      ;
      endcase
    end
  end

  // Read-address generator; r_dx/r_dy/r_rd_d tag the data that returns one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_rd_d <= 1'b0;
    end else begin
      r_rd_d <= bus.mem_rd;
      r_dx   <= r_x;
      r_dy   <= r_y;
      if (w_start_acc) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (r_state == SCAN) begin
        r_addr <= w_last ? '0 : r_addr + AW'(1);
        if (r_x == XW'(COLS - 1)) begin
          r_x <= '0;
          r_y <= (r_y == YW'(ROWS - 1)) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

`ifdef SEARCH_CASE_FOLD_EN
  logic r_fold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          r_fold <= 1'b0;
    else if (w_start_acc) r_fold <= bus.fold;
  end

  always_comb begin
    w_char = r_fold ? CHAR_W'(fold_case(32'(bus.mem_data))) : bus.mem_data;
    for (int i = 0; i < QMAX; i++)
      w_qcmp[i] = r_fold ? CHAR_W'(fold_case(32'(r_query[i]))) : r_query[i];
  end
`else
  logic w_unused_fold;
  assign w_unused_fold = bus.fold;

  always_comb begin
    w_char = bus.mem_data;
    for (int i = 0; i < QMAX; i++) w_qcmp[i] = r_query[i];
  end
`endif

  search_window_cmp #(.QMAX(QMAX), .CHAR_W(CHAR_W)) u_window (
    .clk         (clk),
    .resetn      (resetn),
    .i_valid     (r_rd_d),
    .i_row_start (r_dx == '0),
    .i_char      (w_char),
    .i_query     (w_qcmp),
    .i_len       (r_qlen),
    .o_match     (w_match)
  );

  // Columns dx-len+1 .. dx of the matching row.
  always_comb begin
    for (int c = 0; c < COLS; c++)
      w_mask[c] = (c <= int'(r_dx)) && (c + int'(r_qlen) > int'(r_dx));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int y = 0; y < ROWS; y++) r_bitmap[y] <= '0;
      r_count <= '0;
    end else if (w_start_acc) begin
      for (int y = 0; y < ROWS; y++) r_bitmap[y] <= '0;
      r_count <= '0;
    end else if (w_match) begin
      r_count        <= r_count + CW'(1);
      r_bitmap[r_dy] <= r_bitmap[r_dy] | w_mask;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_hl <= 1'b0;
    else r_hl <= ({1'b0, bus.hl_x} < (XW+1)'(COLS) && {1'b0, bus.hl_y} < (YW+1)'(ROWS)) ?
                 r_bitmap[bus.hl_y][bus.hl_x] : 1'b0;
  end

endmodule

// File: tb/tb_text_search_engine.sv
// Directed and randomized bench for text_search_engine on an 8x2 buffer with a 4-character query.
// Expected results are queued when a scan is started and compared when done pulses.
module tb_text_search_engine;
  import search_pkg::*;

  localparam int COLS = 8, ROWS = 2, QMAX = 4, CHAR_W = 7, N = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  text_search_engine_if #(.COLS(COLS), .ROWS(ROWS), .QMAX(QMAX), .CHAR_W(CHAR_W)) bus ();

  text_search_engine #(.COLS(COLS), .ROWS(ROWS), .QMAX(QMAX), .CHAR_W(CHAR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Text memory: data returns the cycle after mem_rd.
  logic [6:0] tb_mem [N];
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      bus.mem_data <= tb_mem[bus.mem_addr];
      rd_cnt       <= rd_cnt + 1;
    end
  end

  typedef struct packed {
    logic [4:0]  count;
    logic [15:0] bits;   // bit y*8+x
  } exp_t;
  exp_t sb[$];

  logic [6:0] tq [QMAX];
  int         tlen = 0;
  int         checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edit(input logic [1:0] op, input logic [6:0] c);
    bus.q_valid = 1'b1;
    bus.q_op    = op;
    bus.q_char  = c;
    @(negedge clk);
    bus.q_valid = 1'b0;
  endtask

  task automatic set_row(input int y, input string s);
    for (int x = 0; x < COLS; x++) tb_mem[y*COLS + x] = 7'(s[x]);
  endtask

  task automatic set_query(input string s);
    edit(OP_CLEAR, 7'd0);
    tlen = s.len();
    for (int i = 0; i < s.len(); i++) begin
      tq[i] = 7'(s[i]);
      edit(OP_APPEND, 7'(s[i]));
    end
  endtask

  task automatic push_const(input int c, input logic [15:0] b);
    exp_t e;
    e.count = 5'(c);
    e.bits  = b;
    sb.push_back(e);
  endtask

  // Brute force: every column of every row checked against the whole query.
  task automatic push_model();
    int          c = 0;
    logic [15:0] b = '0;
    bit          ok;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        if (x + 1 >= tlen) begin
          ok = 1'b1;
          for (int i = 0; i < tlen; i++)
            if (tb_mem[y*COLS + x - tlen + 1 + i] != tq[i]) ok = 1'b0;
          if (ok) begin
            c++;
            for (int i = 0; i < tlen; i++) b[y*COLS + x - tlen + 1 + i] = 1'b1;
          end
        end
      end
    end
    push_const(c, b);
  endtask

  task automatic read_bitmap(output logic [15:0] bits);
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        bus.hl_x = 3'(x);
        bus.hl_y = 1'(y);
        @(negedge clk);
        bits[y*COLS + x] = bus.hl_o;
      end
    end
  endtask

  // Start a scan, optionally re-pulse start at scan cycle kick_at, then check against the scoreboard.
  task automatic run_scan(input int kick_at, input int exp_lat);
    int          n, rd0;
    logic        b1;
    logic [15:0] bits;
    exp_t        e;
    rd0 = rd_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n  = 1;
    b1 = bus.busy;
    while (bus.done !== 1'b1 && n < 60) begin
      if (n == kick_at) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    check("done_latency", n, exp_lat);
    check("busy_after_start", b1, exp_lat != 1);
    check("read_count", rd_cnt - rd0, (exp_lat == 1) ? 0 : N);
    if (sb.size() == 0) begin
      check("scoreboard_has_entry", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check("match_count", bus.match_count, e.count);
      @(negedge clk);
      check("done_one_cycle", bus.done, 1'b0);
      read_bitmap(bits);
      check("bitmap", bits, e.bits);
    end
  endtask

  initial begin
    int n, dcount;
    string s;
    bus.q_valid = 1'b0;
    bus.q_op    = 2'b00;
    bus.q_char  = '0;
    bus.fold    = 1'b0;
    bus.start   = 1'b0;
    bus.hl_x    = '0;
    bus.hl_y    = '0;
    for (int i = 0; i < N; i++) tb_mem[i] = 7'h78;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q_len", bus.q_len, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_hl_o", bus.hl_o, 0);
    check("rst_match_count", bus.match_count, 0);
    check("rst_q_ready", bus.q_ready, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Two separated matches in row 0.
    set_row(0, "xabxxabx");
    set_row(1, "xxxxxxxx");
    set_query("ab");
    check("q_len_ab", bus.q_len, 2);
    push_const(2, 16'h0066);
    run_scan(0, 18);

    // Overlapping matches.
    set_row(0, "aaaxxxxx");
    set_query("aa");
    push_const(2, 16'h0007);
    run_scan(0, 18);

    // Code 0 is an ordinary character.
    set_row(0, "xxxxxxxx");
    for (int x = 0; x < COLS; x++) tb_mem[COLS + x] = 7'd0;
    edit(OP_CLEAR, 7'd0);
    edit(OP_APPEND, 7'd0);
    edit(OP_APPEND, 7'd0);
    push_const(7, 16'hFF00);
    run_scan(0, 18);

    // No match across the row boundary.
    set_row(0, "xxxxxxxa");
    set_row(1, "bxxxxxxx");
    set_query("ab");
    push_const(0, 16'h0000);
    run_scan(0, 18);

    // Upper-case query against lower-case text: fold only matters when the option is built in.
    set_row(0, "xxabxxxx");
    set_row(1, "xxxxxxxx");
    set_query("AB");
    bus.fold = 1'b1;
`ifdef SEARCH_CASE_FOLD_EN
    push_const(1, 16'h000C);
`else
    push_const(0, 16'h0000);
`endif
    run_scan(0, 18);
    bus.fold = 1'b0;
    push_const(0, 16'h0000);
    run_scan(0, 18);

    // Query length limits and op 11.
    edit(OP_CLEAR, 7'd0);
    check("q_len_clear", bus.q_len, 0);
    s = "abcde";
    for (int i = 0; i < 5; i++) begin
      edit(OP_APPEND, 7'(s[i]));
      check("q_len_append", bus.q_len, (i < 4) ? i + 1 : 4);
    end
    edit(OP_NONE, 7'h7A);
    check("q_len_op11", bus.q_len, 4);
    for (int i = 0; i < 6; i++) begin
      edit(OP_BACKSPACE, 7'd0);
      check("q_len_backspace", bus.q_len, (i < 4) ? 3 - i : 0);
    end
    push_const(0, 16'h0000);
    run_scan(0, 1);

    // Randomized text and query over a two-letter alphabet.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) tb_mem[i] = ($urandom_range(0, 1) != 0) ? 7'h61 : 7'h62;
      s = "";
      for (int i = 0; i < int'($urandom_range(1, QMAX)); i++)
        s = {s, ($urandom_range(0, 1) != 0) ? "a" : "b"};
      set_query(s);
      push_model();
      run_scan(0, 18);
    end

    // start while busy is ignored.
    set_row(0, "abxxabxx");
    set_row(1, "xxxxxxxx");
    set_query("ab");
    push_const(2, 16'h0033);
    run_scan(5, 18);

    // Reset in the middle of a scan.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 5) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_count", bus.match_count, 1);
    check("busy_mid_scan", bus.busy, 1);
    resetn = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_match_count", bus.match_count, 0);
    check("abort_q_len", bus.q_len, 0);
    check("abort_mem_rd", bus.mem_rd, 0);
    check("abort_done", bus.done, 0);
    @(negedge clk);
    resetn = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    check("idle_after_abort", bus.busy, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_search_engine.md
TEXT_SEARCH_ENGINE -- requirements
Module: text_search_engine

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows.
REQ-003 SHALL have parameter QMAX, default 16, meaning maximum query length in characters.
REQ-004 SHALL have parameter CHAR_W, default 7, meaning character code width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports, in this order:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- q_valid  in  1  query-edit request.
- q_ready  out  1  query-edit accept.
- q_op  in  2  edit op: 00 append, 01 backspace, 10 clear, 11 ignored.
- q_char  in  CHAR_W  character for append.
- q_len  out  clog2(QMAX+1)  current query length.
- fold  in  1  case-insensitive request.
- start  in  1  scan request.
- busy  out  1  scan in progress.
- done  out  1  one-cycle scan-complete pulse.
- mem_rd  out  1  text read strobe.
- mem_addr  out  clog2(COLS*ROWS)  text address, row-major y*COLS+x.
- mem_data  in  CHAR_W  read data, valid the cycle after mem_rd.
- hl_x  in  clog2(COLS)  highlight query column.
- hl_y  in  clog2(ROWS)  highlight query row.
- hl_o  out  1  registered highlight bit for (hl_x, hl_y).
- match_count  out  clog2(COLS*ROWS+1)  matches found by last scan.

Function
REQ-006 q_ready SHALL equal !busy; an edit occurs on a clk edge with q_valid && q_ready.
REQ-007 Append SHALL store q_char at index q_len and increment q_len; at q_len==QMAX it is ignored.
REQ-008 Backspace SHALL decrement q_len; at q_len==0 it is a no-op. Clear SHALL set q_len to 0. Op 11 SHALL change nothing.
REQ-009 start SHALL be accepted only when !busy; start while busy SHALL be ignored.
REQ-010 Accepted start SHALL clear the bitmap and match_count in the same edge.
REQ-011 Accepted start with q_len==0 SHALL issue no reads and pulse done on the next cycle, with busy staying low.
REQ-012 FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE->SCAN on an accepted start with q_len>0.
- SCAN issues one read per cycle for addresses 0..COLS*ROWS-1, then moves to DRAIN.
- DRAIN processes the last character, then moves to DONE.
- DONE pulses done, then returns to IDLE.
REQ-013 busy SHALL be high in SCAN and DRAIN; done SHALL be high exactly COLS*ROWS+2 cycles after the start-accepting edge.
REQ-014 The compare window SHALL reset at each row start; matches SHALL NOT span rows.
REQ-015 A match SHALL occur at column x when x+1>=q_len and the last q_len characters of the row equal query[0..q_len-1].
REQ-016 On each match, match_count SHALL increment and bitmap bits x-q_len+1..x of that row SHALL be set.
REQ-017 Overlapping matches SHALL all count: query "aa" on row "aaa" gives 2.
REQ-018 Bitmap and match_count SHALL hold their values until the next accepted start or reset.
REQ-019 hl_o SHALL be the bitmap bit one cycle after hl_x/hl_y are presented; out-of-range coordinates SHALL read 0.
REQ-020 Characters equal to 0 SHALL compare like any other code.

Reset
REQ-021 resetn low SHALL force:
- IDLE, q_len=0, busy=0, done=0, mem_rd=0, mem_addr=0, hl_o=0, match_count=0;
- bitmap all zero, query contents zero.
REQ-022 Reset mid-scan SHALL abort the scan without a done pulse.

Configuration
REQ-023 With SEARCH_CASE_FOLD_EN defined and fold=1, compares SHALL map 'A'-'Z' onto 'a'-'z' on both operands.
REQ-024 Without SEARCH_CASE_FOLD_EN, fold SHALL be ignored and compares SHALL be exact.

Structure
REQ-025 Package search_pkg SHALL hold the q_op encodings, the FSM state enum and the case-fold function.
REQ-026 The rolling window and comparator SHALL be a sub-module search_window_cmp. Its inputs are char, valid, row_start and query/len; its output is match.

Verification (COLS=8, ROWS=2, QMAX=4)
REQ-027 Append 'a','b' then start on row0 "xabxxabx" -> match_count=2, bitmap row0=01100110b (x0 leftmost), done at cycle 18.
REQ-028 Query "aa" on row0 "aaaxxxxx" -> match_count=2, bits x0..x2 set.
REQ-029 Query "ab" with row0 ending 'a' and row1 starting 'b' -> no match across the boundary, match_count=0.
REQ-030 Append five chars, then backspace six times -> q_len goes 4,4,3,2,1,0,0; start -> done next cycle, no mem_rd.
REQ-031 Assert resetn low at scan cycle 5 -> busy=0, match_count=0, no done pulse; pulse start while busy -> ignored.
REQ-032 With SEARCH_CASE_FOLD_EN, query "AB", fold=1, text "ab" -> 1 match; fold=0 -> 0 matches.
